lcd_draw_arbiter: RTL



---
 rtl/lcd_draw_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lcd_draw_arbiter.sv
// Shares the LCD write driver among init sequencer, picture painter and character painter.
// Optional grant watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_draw_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       init_done,
  input  logic [8:0] init_data,
  input  logic       en_write_init,
  input  logic       pic_req,
  input  logic [8:0] pic_data,
  input  logic       en_write_pic,
  input  logic       pic_done,
  input  logic       char_req,
  input  logic [8:0] char_data,
  input  logic       en_write_char,
  input  logic       char_done,
  input  logic       wr_done,
  output logic       show_pic_flag,
  output logic       show_char_flag,
  output logic       wr_done_init,
  output logic       wr_done_pic,
  output logic       wr_done_char,
  output logic [8:0] lcd_data,
  output logic       en_write,
  output logic       busy,
  output logic       err
);

  // state  | meaning
  // S_INIT | init sequencer owns the driver, requests only queue
  // S_IDLE | no grant, arbitrate pending requests
  // S_PIC  | picture painter owns the driver
  // S_CHAR | character painter owns the driver
  typedef enum logic [3:0] {
    S_INIT = 4'b0001,
    S_IDLE = 4'b0010,
    S_PIC  = 4'b0100,
    S_CHAR = 4'b1000
  } state_t;

  localparam logic LAST_PIC  = 1'b0;
  localparam logic LAST_CHAR = 1'b1;

  state_t     state_q, state_d;
  logic       pend_pic_q, pend_pic_d;
  logic       pend_char_q, pend_char_d;
  logic       last_q, last_d;
  logic       show_pic_q, show_pic_d;
  logic       show_char_q, show_char_d;
  logic [8:0] lcd_data_q, lcd_data_d;
  logic       en_write_q, en_write_d;
  logic       grant_pic, grant_char;

`ifdef LCD_ARB_TIMEOUT_EN
  logic [23:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    show_pic_d  = 1'b0;
    show_char_d = 1'b0;
    lcd_data_d  = lcd_data_q;
    en_write_d  = 1'b0;
    grant_pic   = 1'b0;
    grant_char  = 1'b0;

    case (state_q)
      S_INIT: begin
        lcd_data_d = init_data;
        en_write_d = en_write_init;
        if (init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        // with both pending, the source not served last goes first
        if (pend_pic_q && (!pend_char_q || last_q == LAST_CHAR)) begin
          grant_pic = 1'b1;
        end else if (pend_char_q) begin
          grant_char = 1'b1;
        end
      end
      S_PIC: begin
        lcd_data_d = pic_data;
        en_write_d = en_write_pic;
        if (pic_done) state_d = S_IDLE;
      end
      S_CHAR: begin
        lcd_data_d = char_data;
        en_write_d = en_write_char;
        if (char_done) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    if (grant_pic) begin
      state_d    = S_PIC;
      last_d     = LAST_PIC;
      show_pic_d = 1'b1;
    end else if (grant_char) begin
      state_d     = S_CHAR;
      last_d      = LAST_CHAR;
      show_char_d = 1'b1;
    end

    // set wins over the grant-cycle clear
    pend_pic_d  = (pend_pic_q & ~grant_pic) | pic_req;
    pend_char_d = (pend_char_q & ~grant_char) | char_req;

`ifdef LCD_ARB_TIMEOUT_EN
    wdog_d = wdog_q;
    err_d  = 1'b0;
    if (grant_pic || grant_char) begin
      wdog_d = TIMEOUT_CYCLES - 24'd1;
    end else if (state_q == S_PIC || state_q == S_CHAR) begin
      if (wdog_q == 24'd0) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q - 24'd1;
      end
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_INIT;
      pend_pic_q  <= 1'b0;
      pend_char_q <= 1'b0;
      last_q      <= LAST_PIC;
      show_pic_q  <= 1'b0;
      show_char_q <= 1'b0;
      lcd_data_q  <= 9'd0;
      en_write_q  <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
      wdog_q      <= 24'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pend_pic_q  <= pend_pic_d;
      pend_char_q <= pend_char_d;
      last_q      <= last_d;
      show_pic_q  <= show_pic_d;
      show_char_q <= show_char_d;
      lcd_data_q  <= lcd_data_d;
      en_write_q  <= en_write_d;
`ifdef LCD_ARB_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  assign show_pic_flag  = show_pic_q;
  assign show_char_flag = show_char_q;
  assign lcd_data       = lcd_data_q;
  assign en_write       = en_write_q;
  assign busy           = (state_q != S_IDLE);
  assign wr_done_init   = wr_done & (state_q == S_INIT);
  assign wr_done_pic    = wr_done & (state_q == S_PIC);
  assign wr_done_char   = wr_done & (state_q == S_CHAR);

`ifdef LCD_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
